// File: rtl/pixel_readout_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : pixel_readout_buffer_if
// Description : Output sample stream (valid/ready) of the pixel readout buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pixel_readout_buffer_if #(
    parameter int DATA_W = 8
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_idx;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  out_last,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/pixel_readout_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_readout_buffer
// Description : Captures four strobed pixel rows, double-buffers complete
//               frames and streams them out as indexed valid/ready samples.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_readout_buffer #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              read0,
    input  wire logic              read1,
    input  wire logic              read2,
    input  wire logic              read3,
    input  wire logic [DATA_W-1:0] pixData,
    pixel_readout_buffer_if.master out_if,
    output logic [CNT_W-1:0]       frame_cnt,
    output logic                   overflow,
    output logic                   proto_err
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_idx;
    logic [1:0]        w_idx_nxt;
    logic [3:0]        w_rd;
    logic [3:0]        r_rd_prev;
    logic [3:0]        r_mask;
    logic [3:0]        w_mask_nxt;
    logic [DATA_W-1:0] r_cap  [4];
    logic [DATA_W-1:0] r_obuf [4];
    logic [CNT_W-1:0]  r_frame_cnt;
    logic              r_overflow;
    logic              r_proto_err;
    logic              w_multi;
    logic              w_single;
    logic              w_complete;
    logic              w_fire;
    logic              w_final;
    logic              w_load;
    logic              w_drop;

    assign w_rd       = {read3, read2, read1, read0};
    assign w_multi    = |(w_rd & (w_rd - 4'd1));
    assign w_single   = (w_rd != 4'd0) && !w_multi;
    assign w_complete = !read3 && r_rd_prev[3] && (r_mask == 4'hF);
    assign w_fire     = (r_state == SEND) && out_if.out_ready;
    assign w_final    = w_fire && (r_idx == 2'd3);
    // A frame may be swapped in on the very cycle the last sample is accepted.
    assign w_load     = w_complete && ((r_state == EMPTY) || w_final);
    assign w_drop     = w_complete && !w_load;

    always_comb begin
        w_mask_nxt = r_mask;
        if (w_complete) begin
            w_mask_nxt = 4'd0;
        end
        if (w_single) begin
            if (read0 && !r_rd_prev[0]) begin
                w_mask_nxt = 4'b0001;
            end else begin
                w_mask_nxt = w_mask_nxt | w_rd;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (w_load) begin
            w_state_nxt = SEND;
            w_idx_nxt   = 2'd0;
        end else if (w_fire) begin
            w_idx_nxt = r_idx + 2'd1;
            if (r_idx == 2'd3) begin
                w_state_nxt = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= EMPTY;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_prev   <= 4'd0;
            r_mask      <= 4'd0;
            r_frame_cnt <= '0;
            r_overflow  <= 1'b0;
            r_proto_err <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_cap[i]  <= '0;
                r_obuf[i] <= '0;
            end
        end else begin
            r_rd_prev   <= w_rd;
            r_mask      <= w_mask_nxt;
            r_overflow  <= r_overflow | w_drop;
            r_proto_err <= r_proto_err | w_multi;
            if (w_load) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            // obuf takes the pre-edge capture contents, so a read0 that
            // starts the next frame on this same cycle cannot corrupt it.
            for (int i = 0; i < 4; i++) begin
                if (w_single && w_rd[i]) begin
                    r_cap[i] <= pixData;
                end
                if (w_load) begin
                    r_obuf[i] <= r_cap[i];
                end
            end
        end
    end

    assign out_if.out_valid = (r_state == SEND);
    assign out_if.out_data  = r_obuf[r_idx];
    assign out_if.out_idx   = r_idx;
    assign out_if.out_last  = (r_state == SEND) && (r_idx == 2'd3);
    assign frame_cnt        = r_frame_cnt;
    assign overflow         = r_overflow;
    assign proto_err        = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_pixel_readout_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_readout_buffer
// Description : Self-checking bench for pixel_readout_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_readout_buffer;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    typedef struct {
        logic [3:0][7:0] pix;
        int              hold;
        int              stall;
        logic [7:0]      exp_cnt;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic [1:0] i;
        logic       l;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              read0, read1, read2, read3;
    logic [DATA_W-1:0] pixData;
    logic [CNT_W-1:0]  frame_cnt;
    logic              overflow;
    logic              proto_err;

    int   total;
    int   bad;
    exp_t sb[$];

    pixel_readout_buffer_if #(.DATA_W(DATA_W)) bus ();

    pixel_readout_buffer #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .read0     (read0),
        .read1     (read1),
        .read2     (read2),
        .read3     (read3),
        .pixData   (pixData),
        .out_if    (bus),
        .frame_cnt (frame_cnt),
        .overflow  (overflow),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: scoreboard pop on each accepted sample, stall stability.
    initial begin
        exp_t       e;
        logic       prev_stall;
        logic [7:0] prev_data;
        logic [1:0] prev_idx;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_idx   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (prev_stall && bus.out_valid) begin
                    chk("hold_data", bus.out_data, prev_data);
                    chk("hold_idx", bus.out_idx, prev_idx);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: got data=%0h idx=%0d expected no sample",
                                 bus.out_data, bus.out_idx);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", bus.out_data, e.d);
                        chk("out_idx", bus.out_idx, e.i);
                        chk("out_last", bus.out_last, e.l);
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
                prev_idx   = bus.out_idx;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic set_reads(input int n);
        read0 = (n == 0);
        read1 = (n == 1);
        read2 = (n == 2);
        read3 = (n == 3);
    endtask

    task automatic send_frame(input logic [3:0][7:0] p, input int hold, input bit push);
        exp_t e;
        if (push) begin
            for (int k = 0; k < 4; k++) begin
                e.d = p[k];
                e.i = 2'(k);
                e.l = (k == 3);
                sb.push_back(e);
            end
        end
        for (int n = 0; n < 4; n++) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                set_reads(n);
                pixData = p[n];
            end
        end
        @(posedge clk); #1;
        set_reads(-1);
        pixData = 8'h00;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset         = 1'b0;
        set_reads(-1);
        pixData       = 8'h00;
        bus.out_ready = 1'b1;
        sb.delete();
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_idx", bus.out_idx, 0);
        chk("rst_last", bus.out_last, 0);
        chk("rst_cnt", frame_cnt, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_perr", proto_err, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vec_t            tbl[4];
        logic [3:0][7:0] p;

        tbl[0] = '{pix: {8'h44, 8'h33, 8'h22, 8'h11}, hold: 5, stall: 0,  exp_cnt: 8'd1};
        tbl[1] = '{pix: {8'h44, 8'h33, 8'h22, 8'h11}, hold: 5, stall: 10, exp_cnt: 8'd2};
        tbl[2] = '{pix: {8'hA5, 8'h5A, 8'hFF, 8'h00}, hold: 1, stall: 0,  exp_cnt: 8'd3};
        tbl[3] = '{pix: {8'h80, 8'h01, 8'hC3, 8'h7E}, hold: 3, stall: 2,  exp_cnt: 8'd4};

        total         = 0;
        bad           = 0;
        reset         = 1'b0;
        set_reads(-1);
        pixData       = 8'h00;
        bus.out_ready = 1'b1;
        do_reset();

        // Table-driven frames: latency, ordering, stall and counters.
        for (int t = 0; t < 4; t++) begin
            bus.out_ready = (tbl[t].stall == 0);
            send_frame(tbl[t].pix, tbl[t].hold, 1'b1);
            @(negedge clk);
            chk("lat_pre", bus.out_valid, 0);
            if (tbl[t].stall == 0) begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("seq_valid", bus.out_valid, 1);
                    chk("seq_idx", bus.out_idx, k);
                end
                @(negedge clk);
                chk("seq_idle", bus.out_valid, 0);
            end else begin
                @(negedge clk);
                chk("lat_rise", bus.out_valid, 1);
                chk("stall_data0", bus.out_data, tbl[t].pix[0]);
                repeat (tbl[t].stall) @(negedge clk);
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_data", bus.out_data, tbl[t].pix[0]);
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
            wait_drain();
            chk("frame_cnt", frame_cnt, tbl[t].exp_cnt);
            chk("ovf_clear", overflow, 0);
            chk("perr_clear", proto_err, 0);
        end

        // Second frame completes while the first is stalled: dropped.
        do_reset();
        bus.out_ready = 1'b0;
        send_frame({8'h14, 8'h13, 8'h12, 8'h11}, 2, 1'b1);
        send_frame({8'h24, 8'h23, 8'h22, 8'h21}, 2, 1'b0);
        repeat (2) @(negedge clk);
        chk("ovf_set", overflow, 1);
        chk("ovf_cnt", frame_cnt, 1);
        chk("ovf_data", bus.out_data, 8'h11);
        chk("ovf_idx", bus.out_idx, 0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_drain();
        chk("ovf_sticky", overflow, 1);

        // Two strobes at once, then a frame that never saw row 2.
        do_reset();
        @(posedge clk); #1; set_reads(0); pixData = 8'h01;
        @(posedge clk); #1; set_reads(0);
        @(posedge clk); #1; read0 = 1'b0; read1 = 1'b1; read2 = 1'b1; pixData = 8'hEE;
        @(posedge clk); #1; set_reads(1); pixData = 8'h02;
        @(negedge clk);
        chk("perr_set", proto_err, 1);
        @(posedge clk); #1; set_reads(3); pixData = 8'h04;
        @(posedge clk); #1; set_reads(3);
        @(posedge clk); #1; set_reads(-1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("perr_novalid", bus.out_valid, 0);
        end
        chk("perr_cnt", frame_cnt, 0);

        // Reset in the middle of row 2, then a clean frame.
        do_reset();
        @(posedge clk); #1; set_reads(0); pixData = 8'h90;
        @(posedge clk); #1; set_reads(1); pixData = 8'h91;
        @(posedge clk); #1; set_reads(2); pixData = 8'h92;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("async_valid", bus.out_valid, 0);
        chk("async_cnt", frame_cnt, 0);
        @(posedge clk); #1;
        set_reads(-1);
        @(posedge clk); #1;
        reset = 1'b1;
        send_frame({8'hA3, 8'hA2, 8'hA1, 8'hA0}, 5, 1'b1);
        wait_drain();
        chk("rr_cnt", frame_cnt, 1);
        chk("rr_ovf", overflow, 0);
        chk("rr_perr", proto_err, 0);

        // 256 frames wrap the counter.
        do_reset();
        for (int f = 0; f < 256; f++) begin
            p[0] = 8'(f);
            p[1] = 8'(f + 1);
            p[2] = 8'(f * 3);
            p[3] = 8'(f) ^ 8'h3C;
            send_frame(p, 1, 1'b1);
        end
        wait_drain();
        chk("wrap_cnt", frame_cnt, 0);
        chk("wrap_ovf", overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
